// File: rtl/game_core_switch_ctrl.sv
// Shares one VGA output and key set between N_GAMES cores; sequences game changes
// (hold reset, blank until BLANK_FRAMES vsyncs, run) and provides the core clock enable.
module game_core_switch_ctrl #(
    parameter int N_GAMES         = 4,
    parameter int SEL_W           = 2,
    parameter int DB_W            = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RESET_HOLD      = 16,
    parameter int BLANK_FRAMES    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             keys,
    input  logic [N_GAMES-1:0]     core_hsync,
    input  logic [N_GAMES-1:0]     core_vsync,
    input  logic [3*N_GAMES-1:0]   core_rgb,
    output logic [N_GAMES-1:0]     core_reset,
    output logic                   core_clk_en,
    output logic                   left,
    output logic                   right,
    output logic                   hsync,
    output logic                   vsync,
    output logic [2:0]             rgb,
    output logic [SEL_W-1:0]       game_sel,
    output logic                   busy
);
    localparam int HW = $clog2(RESET_HOLD) + 1;
    localparam int FW = $clog2(BLANK_FRAMES) + 1;

    typedef enum logic [1:0] {RST_HOLD, BLANK, RUN} state_t;

    state_t             state, state_n;
    logic [SEL_W-1:0]   sel_n;
    logic [HW-1:0]      hold_cnt, hold_n;
    logic [FW-1:0]      frame_cnt, frame_n;
    logic [N_GAMES-1:0] onehot_n;

    logic [3:0]         ks1, ks2;
    logic [DB_W-1:0]    db_cnt [2];
    logic [1:0]         db_stable, db_pulse;
    logic               next_p, prev_p;
    logic               vs_q, vs_rise;

    // Index 0 is next game (keys[2]), index 1 is previous game (keys[3]).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ks1       <= '0;
            ks2       <= '0;
            db_stable <= '0;
            db_pulse  <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            ks1      <= keys;
            ks2      <= ks1;
            db_pulse <= '0;
            for (int k = 0; k < 2; k++) begin
                if (ks2[k+2] != db_stable[k]) begin
                    if (db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        db_stable[k] <= ks2[k+2];
                        db_pulse[k]  <= ks2[k+2];
                        db_cnt[k]    <= '0;
                    end else begin
                        db_cnt[k] <= db_cnt[k] + DB_W'(1);
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end

    // Coincident next/prev cancel each other.
    assign next_p  = db_pulse[0] & ~db_pulse[1];
    assign prev_p  = db_pulse[1] & ~db_pulse[0];
    assign vs_rise = core_vsync[game_sel] & ~vs_q;

    always_comb begin
        state_n = state;
        sel_n   = game_sel;
        hold_n  = hold_cnt;
        frame_n = frame_cnt;
        case (state)
            RST_HOLD: begin
                if (hold_cnt == HW'(RESET_HOLD - 1)) begin
                    state_n = BLANK;
                    hold_n  = '0;
                end else begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            BLANK: begin
                if (vs_rise) begin
                    if (frame_cnt == FW'(BLANK_FRAMES - 1)) begin
                        state_n = RUN;
                        frame_n = '0;
                    end else begin
                        frame_n = frame_cnt + FW'(1);
                    end
                end
            end
            RUN: begin
                if (next_p || prev_p) begin
                    state_n = RST_HOLD;
                    hold_n  = '0;
                    frame_n = '0;
                    if (next_p)
                        sel_n = (game_sel == SEL_W'(N_GAMES - 1)) ? '0 : game_sel + SEL_W'(1);
                    else
                        sel_n = (game_sel == '0) ? SEL_W'(N_GAMES - 1) : game_sel - SEL_W'(1);
                end
            end
            default: state_n = RST_HOLD;
        endcase
        onehot_n = {{(N_GAMES-1){1'b0}}, 1'b1} << sel_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RST_HOLD;
            game_sel   <= '0;
            hold_cnt   <= '0;
            frame_cnt  <= '0;
            busy       <= 1'b1;
            core_reset <= '1;
        end else begin
            state      <= state_n;
            game_sel   <= sel_n;
            hold_cnt   <= hold_n;
            frame_cnt  <= frame_n;
            busy       <= (state_n != RUN);
            core_reset <= (state_n == RST_HOLD) ? '1 : ~onehot_n;
        end
    end

    // Video is blanked from the same edge that leaves RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_clk_en <= 1'b0;
            vs_q        <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            rgb         <= '0;
        end else begin
            core_clk_en <= ~core_clk_en;
            vs_q        <= core_vsync[game_sel];
            hsync       <= core_hsync[game_sel];
            vsync       <= core_vsync[game_sel];
            rgb         <= (state_n == RUN) ? core_rgb[3*game_sel +: 3] : 3'b000;
        end
    end

    assign left  = (state == RUN) & ks2[0];
    assign right = (state == RUN) & ks2[1];
endmodule

// File: tb/tb_game_core_switch_ctrl.sv
// Directed bench for game_core_switch_ctrl with short debounce/hold parameters.
module tb_game_core_switch_ctrl;
    localparam int NG = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      keys;
    logic [NG-1:0]   core_hsync, core_vsync;
    logic [3*NG-1:0] core_rgb;
    logic [NG-1:0]   core_reset;
    logic            core_clk_en, left, right, hsync, vsync, busy;
    logic [2:0]      rgb;
    logic [1:0]      game_sel;

    game_core_switch_ctrl #(
        .N_GAMES(NG), .SEL_W(2), .DB_W(16),
        .DEBOUNCE_CYCLES(4), .RESET_HOLD(8), .BLANK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .keys(keys),
        .core_hsync(core_hsync), .core_vsync(core_vsync), .core_rgb(core_rgb),
        .core_reset(core_reset), .core_clk_en(core_clk_en),
        .left(left), .right(right), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .game_sel(game_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] k;
        logic [2:0] rgb0;
        logic       hs;
        logic       vs;
        logic       exp_left;
        logic       exp_right;
        logic [2:0] exp_rgb;
        logic       exp_hs;
        logic       exp_vs;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse(input int i);
        core_vsync[i] = 1'b1;
        step(1);
        core_vsync[i] = 1'b0;
        step(1);
    endtask

    task automatic press(input int k, input int n);
        keys[k] = 1'b1;
        step(n);
        keys[k] = 1'b0;
    endtask

    task automatic switch_to(input int k, input logic [1:0] exp_sel);
        logic [3:0] exp_rst;
        exp_rst = ~(4'b0001 << exp_sel);
        press(k, 10);
        check("sw_busy", {31'b0, busy}, 32'd1);
        step(8);
        check("sw_sel", {30'b0, game_sel}, {30'b0, exp_sel});
        check("sw_core_reset", {28'b0, core_reset}, {28'b0, exp_rst});
        check("sw_rgb_blank", {29'b0, rgb}, 32'd0);
        vs_pulse(exp_sel);
        check("sw_busy_1st_vs", {31'b0, busy}, 32'd1);
        vs_pulse(exp_sel);
        check("sw_busy_run", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        //            k     rgb0    hs    vs    left  right rgb     hs    vs
        vecs[0] = '{2'b01, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0};
        vecs[1] = '{2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 1'b1};
        vecs[2] = '{2'b11, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1};
        vecs[3] = '{2'b00, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0};
        vecs[4] = '{2'b00, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0};

        reset      = 1'b1;
        keys       = '0;
        core_hsync = '0;
        core_vsync = '0;
        core_rgb   = {3'b001, 3'b110, 3'b011, 3'b101};
        step(2);
        check("rst_sel", {30'b0, game_sel}, 32'd0);
        check("rst_core_reset", {28'b0, core_reset}, 32'hF);
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_rgb", {29'b0, rgb}, 32'd0);
        check("rst_clk_en", {31'b0, core_clk_en}, 32'd0);
        check("rst_left", {31'b0, left}, 32'd0);

        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check("init_core_reset", {28'b0, core_reset}, (i < 8) ? 32'hF : 32'hE);
            if (i == 1) check("clk_en_1", {31'b0, core_clk_en}, 32'd1);
            if (i == 2) check("clk_en_2", {31'b0, core_clk_en}, 32'd0);
        end

        // BLANK: video dark, keys gated, syncs follow core 0
        check("blank_busy", {31'b0, busy}, 32'd1);
        check("blank_rgb", {29'b0, rgb}, 32'd0);
        keys[1:0] = 2'b11;
        step(3);
        check("blank_left", {31'b0, left}, 32'd0);
        check("blank_right", {31'b0, right}, 32'd0);
        keys[1:0] = 2'b00;
        core_hsync = 4'b0001;
        step(1);
        check("blank_hsync", {31'b0, hsync}, 32'd1);
        core_hsync = '0;
        vs_pulse(0);
        check("blank_busy_1st_vs", {31'b0, busy}, 32'd1);
        check("blank_rgb_1st_vs", {29'b0, rgb}, 32'd0);
        vs_pulse(0);
        check("run_busy", {31'b0, busy}, 32'd0);
        check("run_rgb", {29'b0, rgb}, 32'd5);

        for (int i = 0; i < 5; i++) begin
            keys[1:0]     = vecs[i].k;
            core_rgb[2:0] = vecs[i].rgb0;
            core_hsync[0] = vecs[i].hs;
            core_vsync[0] = vecs[i].vs;
            step(1);
            check("vec_rgb", {29'b0, rgb}, {29'b0, vecs[i].exp_rgb});
            check("vec_hsync", {31'b0, hsync}, {31'b0, vecs[i].exp_hs});
            check("vec_vsync", {31'b0, vsync}, {31'b0, vecs[i].exp_vs});
            step(1);
            check("vec_left", {31'b0, left}, {31'b0, vecs[i].exp_left});
            check("vec_right", {31'b0, right}, {31'b0, vecs[i].exp_right});
        end

        // left latency is exactly two clocks
        keys[0] = 1'b1;
        step(1);
        check("left_lat_1", {31'b0, left}, 32'd0);
        step(1);
        check("left_lat_2", {31'b0, left}, 32'd1);
        keys[0] = 1'b0;
        step(2);

        press(2, 3);
        step(10);
        check("short_sel", {30'b0, game_sel}, 32'd0);
        check("short_busy", {31'b0, busy}, 32'd0);

        begin
            bit seen;
            seen = 1'b0;
            keys[2] = 1'b1;
            for (int i = 0; i < 40 && !seen; i++) begin
                step(1);
                if (busy) seen = 1'b1;
            end
            check("long_busy_rise", {31'b0, seen}, 32'd1);
            keys[2] = 1'b0;
            for (int i = 1; i <= 8; i++) begin
                step(1);
                check("long_core_reset", {28'b0, core_reset}, (i < 8) ? 32'hF : 32'hD);
            end
            check("long_sel", {30'b0, game_sel}, 32'd1);
        end

        // next during BLANK is dropped
        press(2, 12);
        step(8);
        check("blank_next_sel", {30'b0, game_sel}, 32'd1);
        check("blank_next_busy", {31'b0, busy}, 32'd1);
        vs_pulse(1);
        vs_pulse(1);
        check("blank_next_run", {31'b0, busy}, 32'd0);
        check("blank_next_sel2", {30'b0, game_sel}, 32'd1);

        switch_to(2, 2'd2);
        switch_to(2, 2'd3);
        switch_to(2, 2'd0);
        switch_to(3, 2'd3);

        begin
            bit busy_seen;
            busy_seen = 1'b0;
            keys[3:2] = 2'b11;
            for (int i = 0; i < 14; i++) begin
                step(1);
                if (busy) busy_seen = 1'b1;
            end
            keys[3:2] = 2'b00;
            for (int i = 0; i < 10; i++) begin
                step(1);
                if (busy) busy_seen = 1'b1;
            end
            check("both_sel", {30'b0, game_sel}, 32'd3);
            check("both_busy_seen", {31'b0, busy_seen}, 32'd0);
        end

        press(3, 10);
        check("prev_hold_busy", {31'b0, busy}, 32'd1);
        check("prev_hold_sel", {30'b0, game_sel}, 32'd2);
        check("prev_hold_core_reset", {28'b0, core_reset}, 32'hF);
        reset = 1'b1;
        #1;
        check("abort_sel", {30'b0, game_sel}, 32'd0);
        check("abort_core_reset", {28'b0, core_reset}, 32'hF);
        check("abort_rgb", {29'b0, rgb}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd1);
        check("abort_clk_en", {31'b0, core_clk_en}, 32'd0);
        step(2);
        reset = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
